// File: rtl/div_req_sequencer.sv
// div_req_sequencer
// Request sequencer in front of the iterative divider div_int. Requests are
// buffered in a small FIFO and issued one at a time with a one-cycle start
// pulse. The tagged result is held on a valid/ready port until it is consumed.
// Optional build macro: DIV_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// forces a timeout result after TMO_CYCLES cycles without completion.
module div_req_sequencer #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 2,
    parameter int TMO_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_x,
    input  logic [WIDTH-1:0]           in_y,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       div_start,
    output logic [WIDTH-1:0]           div_x,
    output logic [WIDTH-1:0]           div_y,
    input  logic                       div_busy,
    input  logic                       div_valid,
    input  logic                       div_dbz,
    input  logic [WIDTH-1:0]           div_q,
    input  logic [WIDTH-1:0]           div_r,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_q,
    output logic [WIDTH-1:0]           out_r,
    output logic                       out_dbz,
    output logic                       out_timeout,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_x_q   [DEPTH];
    logic [WIDTH-1:0] mem_y_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Control
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       push_s;
    logic       pop_s;
    logic       capture_s;
    logic       in_ready_s;
    logic       fifo_nonempty_s;
    logic       tmo_hit_s;

    // Operands of the request in flight
    logic [WIDTH-1:0] div_x_q;
    logic [WIDTH-1:0] div_y_q;
    logic [TAG_W-1:0] tag_q;

    // Result registers
    logic [WIDTH-1:0] res_quo_q;
    logic [WIDTH-1:0] res_quo_d;
    logic [WIDTH-1:0] res_rem_q;
    logic [WIDTH-1:0] res_rem_d;
    logic             res_dbz_q;
    logic             res_dbz_d;
    logic [TAG_W-1:0] res_tag_q;
    logic [TAG_W-1:0] res_tag_d;

    // The divider's busy flag is informational; completion uses valid/dbz only.
    logic unused_busy_s;
    assign unused_busy_s = div_busy;

    assign in_ready_s      = (count_q < CNT_W'(DEPTH));
    assign fifo_nonempty_s = (count_q != {CNT_W{1'b0}});
    assign push_s          = in_valid & in_ready_s;

    // Next-state logic; pops happen only on entry to ISSUE.
    always_comb begin
        state_d   = state_q;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_nonempty_s) begin
                    pop_s   = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_valid | div_dbz | tmo_hit_s) begin
                    capture_s = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (fifo_nonempty_s) begin
                        pop_s   = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Result selection; divide-by-zero outranks valid, which outranks timeout.
    always_comb begin
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        res_dbz_d = res_dbz_q;
        res_tag_d = res_tag_q;
        if (capture_s) begin
            res_tag_d = tag_q;
            if (div_dbz) begin
                res_quo_d = {WIDTH{1'b1}};
                res_rem_d = div_x_q;
                res_dbz_d = 1'b1;
            end else if (div_valid) begin
                res_quo_d = div_q;
                res_rem_d = div_r;
                res_dbz_d = 1'b0;
            end else begin
                res_quo_d = {WIDTH{1'b0}};
                res_rem_d = {WIDTH{1'b0}};
                res_dbz_d = 1'b0;
            end
        end else begin
            res_tag_d = res_tag_q;
        end
    end

    // FSM state and FIFO pointers/occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i]   <= {WIDTH{1'b0}};
                mem_y_q[i]   <= {WIDTH{1'b0}};
                mem_tag_q[i] <= {TAG_W{1'b0}};
            end
        end else if (push_s) begin
            mem_x_q[wr_ptr_q]   <= in_x;
            mem_y_q[wr_ptr_q]   <= in_y;
            mem_tag_q[wr_ptr_q] <= in_tag;
        end
    end

    // Operand registers loaded by the pop; held stable through ISSUE and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_x_q <= {WIDTH{1'b0}};
            div_y_q <= {WIDTH{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
        end else if (pop_s) begin
            div_x_q <= mem_x_q[rd_ptr_q];
            div_y_q <= mem_y_q[rd_ptr_q];
            tag_q   <= mem_tag_q[rd_ptr_q];
        end
    end

    // Result registers; only a capture in WAIT changes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_quo_q <= {WIDTH{1'b0}};
            res_rem_q <= {WIDTH{1'b0}};
            res_dbz_q <= 1'b0;
            res_tag_q <= {TAG_W{1'b0}};
        end else begin
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            res_dbz_q <= res_dbz_d;
            res_tag_q <= res_tag_d;
        end
    end

`ifdef DIV_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);

    logic [TMO_W-1:0] wait_cnt_q;
    logic [TMO_W-1:0] wait_cnt_d;
    logic             res_tmo_q;
    logic             res_tmo_d;

    // The limit is reached on the TMO_CYCLES-th WAIT cycle (count so far is TMO_CYCLES-1).
    assign tmo_hit_s = (state_q == S_WAIT) && (wait_cnt_q == TMO_W'(TMO_CYCLES - 1));

    // WAIT cycle counter, cleared in ISSUE so it starts at zero on WAIT entry.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_ISSUE) begin
            wait_cnt_d = {TMO_W{1'b0}};
        end else if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Timeout flag is set only when the watchdog, not the divider, ends WAIT.
    always_comb begin
        res_tmo_d = res_tmo_q;
        if (capture_s) begin
            res_tmo_d = ~(div_valid | div_dbz);
        end else begin
            res_tmo_d = res_tmo_q;
        end
    end

    // Watchdog counter and timeout result flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= {TMO_W{1'b0}};
            res_tmo_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            res_tmo_q  <= res_tmo_d;
        end
    end

    assign out_timeout = res_tmo_q;
`else
    assign tmo_hit_s   = 1'b0;
    assign out_timeout = 1'b0;
`endif

    assign in_ready   = in_ready_s;
    assign fifo_count = count_q;
    assign div_start  = (state_q == S_ISSUE);
    assign div_x      = div_x_q;
    assign div_y      = div_y_q;
    assign out_valid  = (state_q == S_HOLD);
    assign out_q      = res_quo_q;
    assign out_r      = res_rem_q;
    assign out_dbz    = res_dbz_q;
    assign out_tag    = res_tag_q;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed testbench for div_req_sequencer with a small behavioural divider
// model (fixed latency, optional hang for the watchdog scenario).
module tb_div_req_sequencer;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_x = 4'd0;
    logic [3:0] in_y = 4'd0;
    logic [1:0] in_tag = 2'd0;
    logic       div_start;
    logic [3:0] div_x;
    logic [3:0] div_y;
    logic       div_busy = 1'b0;
    logic       div_valid = 1'b0;
    logic       div_dbz = 1'b0;
    logic [3:0] div_q = 4'd0;
    logic [3:0] div_r = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_q;
    logic [3:0] out_r;
    logic       out_dbz;
    logic       out_timeout;
    logic [1:0] out_tag;
    logic [2:0] fifo_count;

    int tests_run = 0;
    int tests_failed = 0;
    int start_cnt = 0;

    logic       dm_hang = 1'b0;
    int         dm_cnt = 0;
    logic [3:0] dm_x = 4'd0;
    logic [3:0] dm_y = 4'd0;

    div_req_sequencer #(.WIDTH(4), .DEPTH(4), .TAG_W(2), .TMO_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_busy(div_busy), .div_valid(div_valid), .div_dbz(div_dbz), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
        .out_dbz(out_dbz), .out_timeout(out_timeout), .out_tag(out_tag), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Count start pulses seen by the divider.
    always @(posedge clk) begin
        if (div_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    // Divider model: latches operands on start, pulses valid or dbz LAT cycles later; no reset.
    always @(posedge clk) begin
        div_valid <= 1'b0;
        div_dbz   <= 1'b0;
        if (div_start === 1'b1) begin
            dm_x     <= div_x;
            dm_y     <= div_y;
            dm_cnt   <= dm_hang ? 0 : LAT;
            div_busy <= 1'b1;
        end else if (dm_cnt > 0) begin
            dm_cnt <= dm_cnt - 1;
            if (dm_cnt == 1) begin
                div_busy <= 1'b0;
                if (dm_y == 4'd0) begin
                    div_dbz <= 1'b1;
                    div_q   <= 4'h5;
                    div_r   <= 4'h6;
                end else begin
                    div_valid <= 1'b1;
                    div_q     <= dm_x / dm_y;
                    div_r     <= dm_x % dm_y;
                end
            end
        end
    end

    task automatic push(input logic [3:0] x, input logic [3:0] y, input logic [1:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_y = y; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output int n, output bit ok);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (out_valid === 1'b1);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s_wait: out_valid got %b expected 1 within 100 cycles", name, out_valid);
        end
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (div_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (div_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_start: div_start got %b expected 1 within 50 cycles", name, div_start);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({in_ready, fifo_count, div_start, div_x, div_y, out_valid, out_q, out_r, out_dbz, out_timeout, out_tag}
            !== {1'b1, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h",
                {in_ready, fifo_count, div_start, div_x, div_y, out_valid, out_q, out_r, out_dbz, out_timeout, out_tag},
                {1'b1, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int  s0;
        int  n;
        bit  ok;
        out_ready = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        in_valid = 1'b1; in_x = 4'd7; in_y = 4'd2; in_tag = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if ({fifo_count, div_start} !== {3'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_queued: count/start got %h expected %h", {fifo_count, div_start}, {3'd1, 1'b0});
        end
        @(negedge clk);
        tests_run++;
        if ({div_start, div_x, div_y, fifo_count} !== {1'b1, 4'd7, 4'd2, 3'd0}) begin
            tests_failed++;
            $display("FAIL single_issue: start/x/y/count got %h expected %h",
                {div_start, div_x, div_y, fifo_count}, {1'b1, 4'd7, 4'd2, 3'd0});
        end
        wait_out("single", n, ok);
        tests_run++;
        if (n != 6) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d cycles expected 6", n);
        end
        tests_run++;
        if ({out_q, out_r, out_tag, out_dbz, out_timeout} !== {4'd3, 4'd1, 2'd1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_result: got %h expected %h",
                {out_q, out_r, out_tag, out_dbz, out_timeout}, {4'd3, 4'd1, 2'd1, 1'b0, 1'b0});
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if ((start_cnt - s0) != 1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_one_start: starts got %0d valid %b expected 1 starts valid 0", start_cnt - s0, out_valid);
        end
    endtask

    task automatic test_dbz();
        int n;
        bit ok;
        out_ready = 1'b1;
        push(4'd2, 4'd0, 2'd2);
        wait_out("dbz", n, ok);
        tests_run++;
        if ({out_q, out_r, out_tag, out_dbz, out_timeout} !== {4'hF, 4'd2, 2'd2, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL dbz_result: got %h expected %h",
                {out_q, out_r, out_tag, out_dbz, out_timeout}, {4'hF, 4'd2, 2'd2, 1'b1, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_burst();
        int bx[5] = '{15, 1, 8, 0, 7};
        int by[5] = '{5, 1, 9, 2, 2};
        int bt[5] = '{0, 1, 2, 3, 0};
        int eq[5] = '{3, 1, 0, 0, 3};
        int er[5] = '{0, 0, 8, 0, 1};
        int n;
        bit ok;
        bit seen;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL burst_ready_%0d: in_ready got %b expected 1", i, in_ready);
            end
            in_valid = 1'b1; in_x = 4'(bx[i]); in_y = 4'(by[i]); in_tag = 2'(bt[i]);
        end
        @(negedge clk);
        tests_run++;
        if ({fifo_count, in_ready} !== {3'd4, 1'b0}) begin
            tests_failed++;
            $display("FAIL burst_full: count/ready got %h expected %h", {fifo_count, in_ready}, {3'd4, 1'b0});
        end
        in_x = 4'd9; in_y = 4'd9; in_tag = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL burst_drop: count got %0d expected 4", fifo_count);
        end
        for (int k = 0; k < 5; k++) begin
            wait_out("burst", n, ok);
            tests_run++;
            if ({out_q, out_r, out_tag, out_dbz} !== {4'(eq[k]), 4'(er[k]), 2'(bt[k]), 1'b0}) begin
                tests_failed++;
                $display("FAIL burst_result_%0d: got %h expected %h", k,
                    {out_q, out_r, out_tag, out_dbz}, {4'(eq[k]), 4'(er[k]), 2'(bt[k]), 1'b0});
            end
            @(negedge clk);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL burst_drained: extra valid %b count %0d expected 0 and 0", seen, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int n;
        bit ok;
        out_ready = 1'b0;
        push(4'd15, 4'd5, 2'd3);
        push(4'd7, 4'd2, 2'd1);
        wait_out("bp", n, ok);
        s0 = start_cnt;
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if ({out_valid, out_q, out_r, out_tag, out_dbz, fifo_count, div_start}
                !== {1'b1, 4'd3, 4'd0, 2'd3, 1'b0, 3'd1, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got %h expected %h", c,
                    {out_valid, out_q, out_r, out_tag, out_dbz, fifo_count, div_start},
                    {1'b1, 4'd3, 4'd0, 2'd3, 1'b0, 3'd1, 1'b0});
            end
            @(negedge clk);
        end
        tests_run++;
        if (start_cnt != s0) begin
            tests_failed++;
            $display("FAIL bp_no_start: starts got %0d expected %0d", start_cnt, s0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({div_start, div_x, out_valid, fifo_count} !== {1'b1, 4'd7, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL bp_next_issue: got %h expected %h",
                {div_start, div_x, out_valid, fifo_count}, {1'b1, 4'd7, 1'b0, 3'd0});
        end
        wait_out("bp2", n, ok);
        tests_run++;
        if ({out_q, out_r, out_tag} !== {4'd3, 4'd1, 2'd1}) begin
            tests_failed++;
            $display("FAIL bp_second: got %h expected %h", {out_q, out_r, out_tag}, {4'd3, 4'd1, 2'd1});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        out_ready = 1'b1;
        push(4'd15, 4'd5, 2'd2);
        wait_start("rstmid");
        @(negedge clk);
        in_valid = 1'b1; in_x = 4'd1; in_y = 4'd1; in_tag = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, fifo_count, div_start, div_x, div_y, out_valid, out_q, out_r, out_dbz, out_timeout, out_tag}
            !== {1'b1, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL rstmid_values: got %h expected %h",
                {in_ready, fifo_count, div_start, div_x, div_y, out_valid, out_q, out_r, out_dbz, out_timeout, out_tag},
                {1'b1, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || div_start !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL rstmid_late_valid: activity %b count %0d expected 0 and 0", seen, fifo_count);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        bit seen;
        out_ready = 1'b1;
        dm_hang = 1'b1;
        push(4'd7, 4'd2, 2'd2);
        wait_start("tmo");
`ifdef DIV_SEQ_TIMEOUT_EN
        wait_out("tmo", n, ok);
        tests_run++;
        if (n != 17) begin
            tests_failed++;
            $display("FAIL tmo_latency: got %0d cycles expected 17", n);
        end
        tests_run++;
        if ({out_timeout, out_q, out_r, out_dbz, out_tag} !== {1'b1, 4'd0, 4'd0, 1'b0, 2'd2}) begin
            tests_failed++;
            $display("FAIL tmo_result: got %h expected %h",
                {out_timeout, out_q, out_r, out_dbz, out_tag}, {1'b1, 4'd0, 4'd0, 1'b0, 2'd2});
        end
        @(negedge clk);
`else
        n = 0;
        ok = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || out_timeout !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_disabled: valid/timeout activity got %b expected 0", seen);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        dm_hang = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_burst();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/div_req_sequencer.md
# div_req_sequencer

Request sequencer directly upstream of the iterative integer divider `div_int`. Buffers dividend/divisor/tag requests in a small FIFO and issues each one to the divider with a single-cycle `start` pulse. It then waits for `valid` or `dbz` and presents the tagged quotient/remainder on a valid/ready result port. Only one division is in flight at a time; the FIFO absorbs bursts from the producer while the divider is busy.

## Interface
- `WIDTH`, 4: operand/result width; must match the divider's `WIDTH`.
- `DEPTH`, 4: request FIFO depth; power of two, ≥2.
- `TAG_W`, 2: request tag width.
- `TMO_CYCLES`, 16: watchdog limit in WAIT cycles; used only with `DIV_SEQ_TIMEOUT_EN`.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request offered.
- `in_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `in_x`  in  WIDTH  dividend.
- `in_y`  in  WIDTH  divisor.
- `in_tag`  in  TAG_W  request tag, returned unchanged.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_x`  out  WIDTH  registered dividend, stable from ISSUE through WAIT.
- `div_y`  out  WIDTH  registered divisor, stable from ISSUE through WAIT.
- `div_busy`  in  1  divider busy; informational only, not used for completion.
- `div_valid`  in  1  divider result valid.
- `div_dbz`  in  1  divider divide-by-zero flag.
- `div_q`  in  WIDTH  divider quotient.
- `div_r`  in  WIDTH  divider remainder.
- `out_valid`  out  1  result held for consumer.
- `out_ready`  in  1  consumer accepts the result.
- `out_q`, `out_r`  out  WIDTH  result quotient and remainder.
- `out_dbz`  out  1  result is divide-by-zero.
- `out_timeout`  out  1  result produced by the watchdog.
- `out_tag`  out  TAG_W  tag of the result.
- `fifo_count`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- FIFO: push when `in_valid & in_ready`. Pop occurs only on the transition into ISSUE. The pop copies x/y/tag into `div_x`/`div_y`/an internal tag register. The FIFO has no fall-through: a push into an empty FIFO is visible to the FSM on the following cycle. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave `fifo_count` unchanged.
- FSM states:
  - IDLE: if `fifo_count > 0`, pop and go to ISSUE.
  - ISSUE: `div_start = 1` for exactly this cycle, then go to WAIT.
  - WAIT: on `div_valid | div_dbz`, capture the result into the output registers and go to HOLD.
  - HOLD: `out_valid = 1`. On `out_ready`, go to ISSUE (popping) if `fifo_count > 0`, else go to IDLE.
- `div_start` is decoded as `state == ISSUE`; it is never asserted outside ISSUE.
- Capture rules:
  - `div_valid` with `div_dbz = 0`: `out_q = div_q`, `out_r = div_r`, `out_dbz = 0`.
  - `div_dbz = 1` (takes priority over `div_valid`): `out_q = {WIDTH{1}}`, `out_r = div_x`, `out_dbz = 1`.
- `div_valid` and `div_dbz` are ignored in IDLE, ISSUE and HOLD. Stale or late divider flags therefore never create a result.
- Output registers stay stable while `out_valid & ~out_ready`.

## Timing
- Reset values: state IDLE, FIFO empty, `fifo_count = 0`, `in_ready = 1`, `div_start = 0`, `div_x = div_y = 0`, `out_valid = 0`, `out_q = out_r = 0`, `out_dbz = 0`, `out_timeout = 0`, `out_tag = 0`.
- Latency: request accepted at edge E0. ISSUE occupies the cycle after E1. `out_valid` rises the cycle after the divider's completion flag is first seen in WAIT.
- Back-to-back issue: there is one ISSUE cycle between the HOLD handshake and the next `div_start`.
- FIFO full (`fifo_count = DEPTH`): `in_ready = 0`; pushes are dropped by handshake. A pop on the same edge does not raise `in_ready` until the next cycle.
- Reset mid-operation (any state): everything returns to reset values immediately. The divider has no reset, so its subsequent `valid`/`dbz` is ignored because the FSM is in IDLE.

## Configuration
- `DIV_SEQ_TIMEOUT_EN` defined:
  - A WAIT cycle counter clears on entry to WAIT.
  - If the counter reaches `TMO_CYCLES` without completion, the block goes to HOLD with `out_timeout = 1`, `out_q = out_r = 0`, `out_dbz = 0`.
  - A completion in the same cycle as the limit wins over the timeout.
- Not defined: no counter is built; `out_timeout` is tied to 0; WAIT waits indefinitely.

## Test plan
- Single request 7/2, tag 1, `out_ready = 1` → exactly one `div_start` pulse; result `out_q = 3`, `out_r = 1`, `out_tag = 1`, `out_dbz = 0`.
- Request 2/0 → divider raises `dbz`; result `out_q = 4'hF`, `out_r = 2`, `out_dbz = 1`.
- Burst of 5 requests (15/5, 1/1, 8/9, 0/2, 7/2) with DEPTH = 4 → `in_ready` drops at `fifo_count = 4`. Results come back in order: (3,0), (1,0), (0,8), (0,0), (3,1), with matching tags.
- Hold `out_ready = 0` for 10 cycles after result 15/5 → `out_valid` and outputs remain stable; no new `div_start` during that time; the next request issues one cycle after the handshake.
- Assert `rst` during WAIT of 15/5 → outputs return to reset values immediately. The late `div_valid` produces no `out_valid`; `fifo_count = 0`.
- With `DIV_SEQ_TIMEOUT_EN` and a divider model that never completes → `out_valid` rises with `out_timeout = 1` after 16 WAIT cycles.
